// File: rtl/alu_share_arb_pkg.sv
// Shared ALU definitions: op-code constants, the invalid-code bound and the
// sequencer state encoding used by the arbiter and by any ALU decode.
package alu_defs;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  // Highest legal op code; anything above it is reported as an error.
  localparam logic [3:0] OP_LAST_VALID = OP_SRA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    return op <= OP_LAST_VALID;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters, one op at a
// time: IDLE grants, ISSUE drives the ALU and captures, RESP holds the answer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and once a response valid is raised
// it and its payload stay unchanged until that transfer.
module alu_share_arb
  import alu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req0_op,
  input  logic [3:0]        req1_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              busy,
  output logic [CNT_W-1:0]  op_cnt,
  output logic [1:0]        dbg_state
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]          op_q, op_d;
  logic                id_q, id_d, last_q, last_d;
  logic                zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          gnt;

  rr_arb2 u_rr_arb2 (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    res_d     = res_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // Grant is suppressed while reset is asserted.
        req_ready = gnt & {2{rst_n}};
        if ((req_valid & req_ready) != 2'b00) begin
          id_d    = req_ready[1];
          a_d     = req_ready[1] ? req1_a  : req0_a;
          b_d     = req_ready[1] ? req1_b  : req0_b;
          op_d    = req_ready[1] ? req1_op : req0_op;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (is_valid_op(op_q)) begin
          res_d  = alu_res;
          zero_d = alu_zero;
          ovf_d  = alu_ovf;
          err_d  = 1'b0;
        end else begin
          res_d  = '0;
          zero_d = 1'b0;
          ovf_d  = 1'b0;
          err_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = id_q ? 2'b10 : 2'b01;
        if (rsp_ready[id_q]) begin
          last_d  = id_q;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_res   = res_q;
  assign rsp_zero  = zero_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_cnt    = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural model of the external ALU.
module tb_alu_share_arb;
  import alu_defs::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready, dbg_state;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]        req0_op, req1_op, alu_op;
  logic [DATA_W-1:0] rsp_res, alu_a, alu_b, alu_res;
  logic              rsp_zero, rsp_ovf, rsp_err, alu_zero, alu_ovf, busy;
  logic [CNT_W-1:0]  op_cnt;

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_res(alu_res), .alu_zero(alu_zero),
    .alu_ovf(alu_ovf), .busy(busy), .op_cnt(op_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // External ALU model; illegal codes produce junk that the DUT must mask.
  function automatic logic [DATA_W+1:0] alu_ref(input logic [3:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic o;
    o = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SLL:  r = a << b[4:0];
      OP_NOR:  r = ~(a | b);
      OP_SRL:  r = a >> b[4:0];
      OP_SUB:  begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      OP_XOR:  r = a ^ b;
      OP_SLTU: r = {31'd0, a < b};
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      default: begin r = 32'hdead_beef; o = 1'b1; end
    endcase
    return {o, (op > OP_LAST_VALID) ? 1'b1 : (r == '0), r};
  endfunction

  always_comb begin
    {alu_ovf, alu_zero, alu_res} = alu_ref(alu_op, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One complete op from a single requester with the response accepted at once.
  task automatic do_op(input logic id, input logic [3:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [DATA_W-1:0] e_res, input logic e_zero,
                       input logic e_ovf, input logic e_err);
    logic [1:0] bit_id;
    bit_id = id ? 2'b10 : 2'b01;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_a = a; req0_b = b; req0_op = op; end
    req_valid = bit_id;
    rsp_ready = 2'b11;
    #1;
    check("op_req_ready", 32'(req_ready), 32'(bit_id));
    tick();
    req_valid = 2'b00;
    check("op_issue_busy", 32'(busy), 32'd1);
    check("op_issue_no_rsp", 32'(rsp_valid), 32'd0);
    check("op_issue_alu_a", alu_a, a);
    check("op_issue_alu_b", alu_b, b);
    check("op_issue_alu_op", 32'(alu_op), 32'(op));
    tick();
    check("op_rsp_valid", 32'(rsp_valid), 32'(bit_id));
    check("op_rsp_res", rsp_res, e_res);
    check("op_rsp_zero", 32'(rsp_zero), 32'(e_zero));
    check("op_rsp_ovf", 32'(rsp_ovf), 32'(e_ovf));
    check("op_rsp_err", 32'(rsp_err), 32'(e_err));
    tick();
    check("op_back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_gnt [3];
    logic [DATA_W-1:0] exp_res [3];
    logic [DATA_W+1:0] ref_v;
    logic [CNT_W-1:0] cnt_before;

    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_op = '0; req1_op = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_rsp_res", rsp_res, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Basic add, response at T+2, op_cnt advances to 1.
    do_op(1'b0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
    check("add_op_cnt", 32'(op_cnt), 32'd1);

    // Contention from the first cycle after reset: 0, 1, 0.
    do_reset();
    req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
    req1_a = 32'd3; req1_b = 32'd4; req1_op = OP_OR;
    req_valid = 2'b11; rsp_ready = 2'b11;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
    exp_res[0] = 32'd2; exp_res[1] = 32'd7; exp_res[2] = 32'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(exp_gnt[i]));
      tick();
      check("rr_issue_no_ready", 32'(req_ready), 32'd0);
      tick();
      check("rr_rsp_valid", 32'(rsp_valid), 32'(exp_gnt[i]));
      check("rr_rsp_res", rsp_res, exp_res[i]);
      check("rr_no_ready_in_resp", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 2'b00;
    check("rr_op_cnt", 32'(op_cnt), 32'd3);

    // Stalled response from requester 1 stays stable.
    req1_a = 32'd9; req1_b = 32'd9; req1_op = OP_SUB;
    req_valid = 2'b10; rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'h2);
      check("stall_rsp_res", rsp_res, 32'd0);
      check("stall_rsp_zero", 32'(rsp_zero), 32'd1);
      if (i < 4) tick();
    end
    rsp_ready = 2'b01;
    tick();
    check("stall_wrong_ready_held", 32'(rsp_valid), 32'h2);
    rsp_ready = 2'b10;
    tick();
    check("stall_idle_after_ready", 32'(busy), 32'd0);
    check("stall_op_cnt", 32'(op_cnt), 32'd4);

    // Illegal op code is masked to an error response.
    do_op(1'b0, 4'd12, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1);
    // Signed overflow, signed/unsigned compares, arithmetic shift.
    do_op(1'b1, OP_ADD, 32'h7fff_ffff, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, OP_SLT, 32'hffff_ffff, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, OP_SLTU, 32'hffff_ffff, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    do_op(1'b1, OP_SRA, 32'h8000_0000, 32'd4, 32'hf800_0000, 1'b0, 1'b0, 1'b0);

    // Reset during RESP abandons the op.
    do_reset();
    req0_a = 32'd2; req0_b = 32'd2; req0_op = OP_ADD;
    req_valid = 2'b01; rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    check("abort_in_resp", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    tick();
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_op_cnt", 32'(op_cnt), 32'd0);
    rst_n = 1'b1;
    do_op(1'b1, OP_XOR, 32'hf0f0, 32'h0ff0, 32'hff00, 1'b0, 1'b0, 1'b0);
    check("abort_then_op_cnt", 32'(op_cnt), 32'd1);

    // Counter wrap with CNT_W=4: 15 ops, then one more returns to 0.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      ref_v = alu_ref(4'(i % 11), 32'(i * 37), 32'(i));
      do_op(1'(i % 2), 4'(i % 11), 32'(i * 37), 32'(i),
            ref_v[DATA_W-1:0], ref_v[DATA_W], ref_v[DATA_W+1], 1'b0);
    end
    cnt_before = op_cnt;
    check("wrap_pre_cnt", 32'(cnt_before), 32'd15);
    do_op(1'b0, OP_AND, 32'hff, 32'h0f, 32'h0f, 1'b0, 1'b0, 1'b0);
    check("wrap_cnt_zero", 32'(op_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter DATA_W, 32, operand/result width; must match the shared ALU.
REQ-002 Parameter CNT_W, 16, width of the completed-operation counter.
REQ-003 Port clk input 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n input 1: reset, synchronous and active-low.
REQ-005 Port req_valid input 2: per-requester request valid (bit 0 = requester 0).
REQ-006 Port req_ready output 2: per-requester request accept.
REQ-007 Ports req0_a, req0_b, req1_a, req1_b input DATA_W each: requester operands.
REQ-008 Ports req0_op, req1_op input 4 each: ALU operation codes.
REQ-009 Port rsp_valid output 2: per-requester response valid.
REQ-010 Port rsp_ready input 2: per-requester response accept.
REQ-011 Port rsp_res output DATA_W: shared response result.
REQ-012 Ports rsp_zero, rsp_ovf, rsp_err output 1 each: shared response flags.
REQ-013 Ports alu_a, alu_b output DATA_W and alu_op output 4: drive the external combinational ALU.
REQ-014 Ports alu_res input DATA_W and alu_zero, alu_ovf input 1: ALU results.
REQ-015 Port busy output 1: high whenever state is not IDLE.
REQ-016 Port op_cnt output CNT_W: count of completed response handshakes.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-018 In IDLE, grant: one valid requester -> that one; both valid -> the one not served last; none -> no grant.
REQ-019 req_ready[i] SHALL be high only in IDLE for the granted i; both bits are never high together.
REQ-020 On a req handshake at cycle T: capture operands, op and requester id; go to ISSUE at T+1.
REQ-021 In ISSUE, alu_a/alu_b/alu_op SHALL come from the captured registers; capture alu_res/zero/ovf at end of cycle; go to RESP.
REQ-022 rsp_valid[id] SHALL be high from T+2 and held, with rsp_* stable, until rsp_ready[id] is high.
REQ-023 Only rsp_valid[id] SHALL be asserted; the other bit stays low.
REQ-024 On a response handshake: go to IDLE next cycle, increment op_cnt, and record id as last served.
REQ-025 No new request SHALL be accepted in the response-handshake cycle; minimum spacing is 3 cycles per op.
REQ-026 Valid op codes are 0 and, 1 or, 2 add, 3 sll, 4 nor, 5 srl, 6 sub, 7 slt, 8 xor, 9 sltu, 10 sra.
REQ-027 For op codes 11-15: rsp_err=1 and rsp_res=0, rsp_zero=0, rsp_ovf=0 regardless of ALU outputs; the FSM timing is unchanged.
REQ-028 For valid op codes, rsp_err SHALL be 0 and the result and flags are the ALU values captured in ISSUE.
REQ-029 op_cnt SHALL wrap from all-ones to 0 without any other effect.
REQ-030 Deasserting req_valid while not ready SHALL have no effect; a request is only taken on a handshake.
REQ-031 Outside ISSUE, alu_* SHALL keep the last captured values; they are not required to be zero.

Reset
REQ-032 When rst_n=0 at a clock edge: state=IDLE, last served=1 (requester 0 wins the first contention).
REQ-033 Reset SHALL clear all operand, op and response registers and op_cnt to 0.
REQ-034 During and after reset: rsp_valid=0, req_ready follows IDLE grant only after rst_n=1, busy=0.
REQ-035 Reset in ISSUE or RESP SHALL abandon the operation without a response and without an op_cnt increment.

Structure
REQ-036 ALU op-code constants, the invalid-code bound and the FSM state encodings SHALL live in a shared package, alu_defs, that the ALU decode also uses.
REQ-037 Round-robin grant logic SHALL be one sub-module, rr_arb2: inputs req[1:0] and last; output one-hot gnt[1:0].
REQ-038 The ALU itself SHALL NOT be instantiated inside alu_share_arb.

Verification
REQ-039 Check: req0 add a=5 b=7 at T; rsp_ready held high -> rsp_valid=01 at T+2, res=12, zero=0, ovf=0, op_cnt=1.
REQ-040 Check: both valid from the first cycle after reset -> req0 served first, then req1, then req0; never two ready bits high.
REQ-041 Check: req1 sub a=9 b=9, rsp_ready low for 5 cycles -> rsp_valid=10 held with res=0, zero=1; IDLE one cycle after ready.
REQ-042 Check: req0 op=12 -> rsp_err=1, res=0, response at T+2.
REQ-043 Check: rst_n low during RESP -> rsp_valid=0 next cycle; op_cnt unchanged at 0; next request gives a normal response.
REQ-044 Check: op_cnt preloaded by 65535 completed ops (or CNT_W=4, 15 ops) -> one more op wraps op_cnt to 0.
